// File: rtl/pipe_alu_pkg.sv
// Shared operation encodings for the pipelined ALU.
package pipe_alu_pkg;

  localparam logic [1:0] OP_PASS_A = 2'd0;
  localparam logic [1:0] OP_PASS_B = 2'd1;
  localparam logic [1:0] OP_ADD    = 2'd2;
  localparam logic [1:0] OP_ACC    = 2'd3;

endpackage

// File: rtl/pipe_alu_core.sv
// Combinational datapath: selects or adds operands and flags carry and zero.
module pipe_alu_core
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum;

  // The extra top bit stays 0 for the pass operations, so carry is 0 there.
  always_comb begin
    sum = '0;
    case (op)
      OP_PASS_A: sum = {1'b0, a};
      OP_PASS_B: sum = {1'b0, b};
      OP_ADD:    sum = {1'b0, a} + {1'b0, b};
      default:   sum = {1'b0, base} + {1'b0, a};
    endcase
  end

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];
  assign zero   = (sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/pipe_alu.sv
// Two-stage pipelined ALU with valid/ready handshakes and a persistent accumulator.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] izlaz,
  output logic             carry,
  output logic             zero
);

  logic             en;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [1:0]       s1_op_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] izlaz_reg;
  logic             carry_reg;
  logic             zero_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_zero;
  logic             acc_commit;

  assign en         = !out_valid_reg || out_ready;
  assign in_ready   = en;
  // A clear in the same cycle as an accumulate makes the sum start from zero.
  assign base       = acc_clr ? '0 : acc_reg;
  assign acc_commit = en && s1_valid_reg && (s1_op_reg == OP_ACC);

  pipe_alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_reg),
    .b      (s1_b_reg),
    .op     (s1_op_reg),
    .base   (base),
    .result (core_result),
    .carry  (core_carry),
    .zero   (core_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_op_reg     <= OP_PASS_A;
      out_valid_reg <= 1'b0;
      izlaz_reg     <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b1;
      acc_reg       <= '0;
    end else begin
      if (en) begin
        s1_valid_reg  <= in_valid;
        s1_a_reg      <= a;
        s1_b_reg      <= b;
        s1_op_reg     <= op;
        out_valid_reg <= s1_valid_reg;
        // Bubbles leave the last result untouched on the outputs.
        if (s1_valid_reg) begin
          izlaz_reg <= core_result;
          carry_reg <= core_carry;
          zero_reg  <= core_zero;
        end
      end
      if (acc_commit) begin
        acc_reg <= core_result;
      end else if (acc_clr) begin
        acc_reg <= '0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign izlaz     = izlaz_reg;
  assign carry     = carry_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu: directed 8-bit vectors plus a 16-bit random stream.
module tb_pipe_alu;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       v8, rdy8, clr8, ov8, ordy8, c8, z8;
  logic [7:0] a8, b8, y8;
  logic [1:0] op8;

  logic        v16, rdy16, clr16, ov16, ordy16, c16, z16;
  logic [15:0] a16, b16, y16;
  logic [1:0]  op16;

  exp_t q8[$];
  exp_t q16[$];

  int checks = 0;
  int errors = 0;
  int stall8_cnt = 0;
  bit done16 = 1'b0;
  logic [15:0] acc16 = '0;

  pipe_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .op(op8),
    .acc_clr(clr8), .out_valid(ov8), .out_ready(ordy8), .izlaz(y8), .carry(c8), .zero(z8)
  );

  pipe_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16), .op(op16),
    .acc_clr(clr16), .out_valid(ov16), .out_ready(ordy16), .izlaz(y16), .carry(c16), .zero(z16)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end else begin
      $display("ok   %s = %h", nm, got);
    end
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                       input logic [7:0] er, input logic ec, input logic ez, input bit push);
    bit ok;
    int n;
    a8 = ta; b8 = tb_; op8 = top; v8 = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk); ok = rdy8;
      @(posedge clk); n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send8 timeout got in_ready 0 required 1");
    end else if (push) begin
      q8.push_back('{r: {8'd0, er}, c: ec, z: ez});
    end
    #1 v8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] ta, input logic [15:0] tb_, input logic [1:0] top,
                        input logic [15:0] er, input logic ec, input logic ez);
    bit ok;
    int n;
    a16 = ta; b16 = tb_; op16 = top; v16 = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk); ok = rdy16;
      @(posedge clk); n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send16 timeout got in_ready 0 required 1");
    end else begin
      q16.push_back('{r: er, c: ec, z: ez});
    end
    #1 v16 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain timeout got %0d/%0d pending required 0", q8.size(), q16.size());
    end
    @(posedge clk); #1;
  endtask

  // Random 16-bit word with the expected result from a reference model.
  task automatic rand16();
    logic [15:0] ra, rb, r;
    logic [1:0]  rop;
    logic [16:0] s;
    ra = 16'($urandom); rb = 16'($urandom); rop = 2'($urandom_range(0, 3));
    case (rop)
      2'd0:    s = {1'b0, ra};
      2'd1:    s = {1'b0, rb};
      2'd2:    s = {1'b0, ra} + {1'b0, rb};
      default: s = {1'b0, acc16} + {1'b0, ra};
    endcase
    r = s[15:0];
    if (rop == 2'd3) acc16 = r;
    send16(ra, rb, rop, r, s[16], (r == 16'd0));
  endtask

  initial begin : mon8
    exp_t e;
    logic stall_prev;
    logic [7:0] held;
    stall_prev = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && ov8) chk("hold8", 32'(y8), 32'(held));
        if (ov8 && !ordy8) begin
          chk("inready_stall8", 32'(rdy8), 32'd0);
          stall8_cnt++;
          held = y8;
          stall_prev = 1'b1;
        end else begin
          stall_prev = 1'b0;
        end
        if (ov8 && ordy8) begin
          if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL out8 unexpected result got %h required none", y8);
          end else begin
            e = q8.pop_front();
            chk("out8 {c,z,y}", 32'({c8, z8, y8}), 32'({e.c, e.z, e.r[7:0]}));
          end
        end
      end
    end
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov16 && ordy16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL out16 unexpected result got %h required none", y16);
        end else begin
          e = q16.pop_front();
          chk("out16 {c,z,y}", 32'({c16, z16, y16}), 32'({e.c, e.z, e.r}));
        end
      end
    end
  end

  initial begin : main
    rst = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; clr8 = 1'b0; ordy8 = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; clr16 = 1'b0; ordy16 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_zero", 32'(z8), 32'd1);
    chk("rst_in_ready", 32'(rdy8), 32'd1);
    chk("rst_izlaz", 32'(y8), 32'd0);

    // Pass operations and two-cycle latency.
    send8(8'hFF, 8'h00, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b1);
    chk("latency_s1", 32'(ov8), 32'd0);
    @(posedge clk); #1;
    chk("latency_s2", 32'(ov8), 32'd1);
    send8(8'hFF, 8'h00, 2'd1, 8'h00, 1'b0, 1'b1, 1'b1);

    // Addition with and without carry.
    send8(8'hFF, 8'h01, 2'd2, 8'h00, 1'b1, 1'b1, 1'b1);
    send8(8'h7F, 8'h01, 2'd2, 8'h80, 1'b0, 1'b0, 1'b1);

    // Back-to-back accumulation.
    send8(8'h10, 8'h00, 2'd3, 8'h10, 1'b0, 1'b0, 1'b1);
    send8(8'h20, 8'h00, 2'd3, 8'h30, 1'b0, 1'b0, 1'b1);
    send8(8'hF0, 8'h00, 2'd3, 8'h20, 1'b1, 1'b0, 1'b1);
    drain();

    // Clear held while the accumulate word sits in stage 1.
    clr8 = 1'b1;
    send8(8'h05, 8'h00, 2'd3, 8'h05, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 clr8 = 1'b0;
    drain();

    // Backpressure: 3 stalled cycles while 4 words stream through.
    stall8_cnt = 0;
    fork
      begin
        send8(8'h01, 8'h02, 2'd2, 8'h03, 1'b0, 1'b0, 1'b1);
        send8(8'h00, 8'h44, 2'd1, 8'h44, 1'b0, 1'b0, 1'b1);
        send8(8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        send8(8'h07, 8'h00, 2'd3, 8'h0C, 1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 ordy8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 ordy8 = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", 32'(stall8_cnt), 32'd3);

    // Reset with two accumulate words in flight: neither may appear, acc returns to 0.
    ordy8 = 1'b0;
    send8(8'h11, 8'h00, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    send8(8'h22, 8'h00, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ordy8 = 1'b1;
    chk("rst_mid_out_valid", 32'(ov8), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_flush", 32'(ov8), 32'd0);
    end
    @(posedge clk); #1;
    send8(8'h00, 8'h00, 2'd3, 8'h00, 1'b0, 1'b1, 1'b1);
    drain();

    // 16-bit instance: wrap-around carry, then random stream with random backpressure.
    send16(16'hFFFF, 16'h0001, 2'd2, 16'h0000, 1'b1, 1'b1);
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          rand16();
        end
        done16 = 1'b1;
      end
      begin
        while (!done16) begin
          @(posedge clk);
          #1 ordy16 = 1'($urandom_range(0, 1));
        end
        ordy16 = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised, pipelined successor of the 8-bit two-input selector: WIDTH-bit operands `a`/`b`, a 2-bit operation code (pass a, pass b, add, accumulate), valid/ready handshakes on both sides and a persistent accumulator. It sits between an operand source and a result consumer in the lab datapath. Throughput is one operation per cycle with a fixed two-cycle latency.

## Interface
- `WIDTH`, default 8: operand, result and accumulator width (≥2).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand word present.
- `in_ready`  out  1  block accepts operand word this cycle.
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand.
- `op`  in  2  operation: 0 pass `a`, 1 pass `b`, 2 `a+b`, 3 `acc+a`.
- `acc_clr`  in  1  synchronous accumulator clear.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result this cycle.
- `izlaz`  out  WIDTH  result.
- `carry`  out  1  carry-out of ops 2/3; 0 for ops 0/1.
- `zero`  out  1  `izlaz == 0`.

## Operation
- Two register stages. S1 holds `{a,b,op}` plus valid bit. S2 holds `{izlaz,carry,zero}` plus valid bit (`out_valid`).
- Global enable `en = !out_valid || out_ready`; `in_ready = en`. When `en`: S1 loads inputs with `s1_valid <= in_valid`; S2 loads computed result with `out_valid <= s1_valid`. When `!en`: both stages and the accumulator hold.
- Accept = `in_valid && in_ready`. Delivery = `out_valid && out_ready`.
- Compute from S1 contents: ops 0/1 select operand, carry 0. Op 2: `{carry,izlaz} = a + b`, computed at WIDTH+1 bits. Op 3: `{carry,izlaz} = base + a`, with `base = acc_clr ? 0 : acc`, and `acc <= izlaz` when the op moves into S2.
- Arithmetic is unsigned and wraps modulo 2^WIDTH. Overflow is reported only via `carry`.
- `acc_clr` acts in the cycle it is high, regardless of `en`. If an op 3 commits in the same cycle, the clear applies first: the result equals `a`, and `acc` becomes `a`.
- `acc` is not directly visible; it is observed only through op 3 results.
- Invalid S1 bubbles never update `acc` and never raise `out_valid`.

## Timing
- Reset (`rst` high at an edge): `out_valid=0`, `izlaz=0`, `carry=0`, `zero=1`, `s1_valid=0`, `acc=0`. `in_ready` is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight words. No result of a word accepted before reset is ever delivered.
- Latency: a word accepted at edge N appears with `out_valid=1` after edge N+1, if `en` stays high.
- Backpressure: `out_valid && !out_ready` holds `izlaz`/`carry`/`zero` stable and drops `in_ready` combinationally in the same cycle. At most 2 words are in flight.
- Full throughput: `in_valid=out_ready=1` continuously gives one result per cycle, in order.
- Simultaneous accept and delivery in one cycle is legal and loses nothing.
- Back-to-back op 3 words accumulate correctly with no bubbles needed, because `acc` updates on the S1→S2 transfer.

## Structure
- Package `pipe_alu_pkg`: localparams `OP_PASS_A=2'd0`, `OP_PASS_B=2'd1`, `OP_ADD=2'd2`, `OP_ACC=2'd3`.
- Sub-module `pipe_alu_core`: purely combinational. Inputs `a`, `b`, `op`, `base`; outputs `result`, `carry`, `zero`; parametrised by WIDTH.
- Top level `pipe_alu` owns both pipeline stages, `en`, and the accumulator register.

## Test plan
- After reset, check `out_valid=0`, `zero=1`, `in_ready=1`. Then accept `a=0xFF, b=0x00, op=0`: exactly 2 edges later `izlaz=0xFF`, `carry=0`, `zero=0`. Then `op=1` gives `izlaz=0x00`, `zero=1`.
- Send `op=2` with `a=0xFF, b=0x01`: `izlaz=0x00`, `carry=1`, `zero=1`. Send `0x7F+0x01`: `izlaz=0x80`, `carry=0`.
- Send back-to-back op 3 words `a=0x10, 0x20, 0xF0`: results `0x10`, `0x30`, `0x20` with `carry=1` on the third. Then pulse `acc_clr` with `a=0x05, op=3`: result `0x05`.
- Backpressure: stream 4 words, hold `out_ready=0` for 3 cycles. `in_ready` must go 0, `izlaz` must stay stable, and all 4 results must arrive in order with no loss or duplication.
- Assert `rst` while 2 words are in flight: no `out_valid` for either word, `acc` reads back as 0 via `op=3, a=0x00` → `izlaz=0x00`, `zero=1`.
- WIDTH=16 instance: `0xFFFF+0x0001` gives `izlaz=0x0000`, `carry=1`. Random streaming with random `out_ready` must match a scoreboard model.
